// File: rtl/inverse_pkg.sv
// Shared types and constants for the 6x6 matrix-inverse pipeline.
package inverse_pkg;

    localparam int N    = 6;
    localparam int W    = 27;
    localparam int FRAC = 16;

    // Width of the i/j/k element indices
    localparam int IDX_W = 3;

    typedef logic signed [W-1:0]       fixed_t;
    typedef fixed_t [N-1:0][N-1:0]     matrix_t;
    typedef logic [IDX_W-1:0]          idx_t;

    localparam idx_t IDX_LAST = idx_t'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        WRITE,
        DONE
    } ltt_state_t;

endpackage

// File: rtl/fixed_mult.sv
// Combinational signed Q10.16 multiply.
// The result is the [FRAC+W-1:FRAC] slice of the full product, which is an
// arithmetic shift right by FRAC (floor toward -inf) wrapped to W bits.
module fixed_mult
    import inverse_pkg::*;
(
    input  fixed_t a,
    input  fixed_t b,
    output fixed_t p
);

    logic signed [2*W-1:0] w_full;
    logic                  w_unused;

    assign w_full = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    assign p      = w_full[FRAC+W-1:FRAC];

    // Discarded fraction bits and high overflow bits
    assign w_unused = ^{w_full[2*W-1:FRAC+W], w_full[FRAC-1:0]};

endmodule

// File: rtl/ltt_block.sv
// Forms the full symmetric inverse A^-1 = K^T * K from the lower-triangular
// inverse K = L^-1, using one time-multiplexed multiply-accumulate unit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// LOAD  | capture K, clear indices, accumulator and result registers
// MAC   | acc += K[k][i]*K[k][j] for k = i .. N-1
// WRITE | store acc into inverse[i][j] and [j][i], step to next (i,j)
// DONE  | one-cycle done pulse, then back to IDLE
module ltt_block
    import inverse_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    en,
    input  logic    start,
    input  matrix_t lt_inverse,
    output logic    busy,
    output logic    done,
    output matrix_t inverse
);

    ltt_state_t r_state;
    ltt_state_t w_next;

    matrix_t    r_k_copy;
    matrix_t    r_inverse;
    fixed_t     r_acc;
    idx_t       r_i;
    idx_t       r_j;
    idx_t       r_k;

    fixed_t     w_op_a;
    fixed_t     w_op_b;
    fixed_t     w_prod;
    logic       w_last_elem;

    assign w_op_a      = r_k_copy[r_k][r_i];
    assign w_op_b      = r_k_copy[r_k][r_j];
    assign w_last_elem = (r_i == IDX_LAST) && (r_j == IDX_LAST);

    fixed_mult u_mult (
        .a (w_op_a),
        .b (w_op_b),
        .p (w_prod)
    );

    // State register; a low enable freezes the sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = MAC;
            MAC:     if (r_k == IDX_LAST) w_next = WRITE;
            WRITE:   w_next = w_last_elem ? DONE : MAC;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: K capture, accumulation, result write-back and index walk
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k_copy  <= '0;
            r_inverse <= '0;
            r_acc     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
        end else if (en) begin
            case (r_state)
                LOAD: begin
                    r_k_copy  <= lt_inverse;
                    r_inverse <= '0;
                    r_acc     <= '0;
                    r_i       <= '0;
                    r_j       <= '0;
                    r_k       <= '0;
                end
                MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (r_k != IDX_LAST) begin
                        r_k <= r_k + idx_t'(1);
                    end
                end
                WRITE: begin
                    r_inverse[r_i][r_j] <= r_acc;
                    r_inverse[r_j][r_i] <= r_acc;
                    r_acc               <= '0;
                    // Row-major walk over the lower triangle; k restarts at
                    // the row index because K is lower triangular.
                    if (r_j < r_i) begin
                        r_j <= r_j + idx_t'(1);
                        r_k <= r_i;
                    end else if (r_i != IDX_LAST) begin
                        r_i <= r_i + idx_t'(1);
                        r_j <= '0;
                        r_k <= r_i + idx_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    // A pending done waits out a stalled cycle
    assign done    = (r_state == DONE) && en;
    assign inverse = r_inverse;

endmodule
